// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared widths, FSM state encoding and response FIFO depth
//               for the memory-port initiator.
// Revision    : 1.0
// ============================================================================
package mem_pkg;

    localparam int AW        = 8;
    localparam int DW        = 8;
    localparam int LEN_W     = 4;
    localparam int RSP_DEPTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_rsp_fifo
// Description : Small circular FIFO for read responses; push and pop may
//               occur in the same cycle.
// Revision    : 1.0
// ============================================================================
module mem_rsp_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= push_data;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_data = r_mem[r_rptr];
    assign count    = r_count;
    assign full     = (r_count == CW'(DEPTH));
    assign empty    = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
// Module      : mem_initiator
// Description : Burst read/write initiator for a synchronous-read,
//               write-first memory port with a flow-controlled read channel.
// Revision    : 1.0
// ============================================================================
module mem_initiator #(
    parameter int AW    = mem_pkg::AW,
    parameter int DW    = mem_pkg::DW,
    parameter int LEN_W = mem_pkg::LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [DW-1:0]    wr_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_data,
    output logic             rsp_last,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_d_i,
    input  logic [DW-1:0]    mem_d_o,
    output logic             busy
);

    import mem_pkg::*;

    localparam int CW = $clog2(RSP_DEPTH + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_cur_addr;
    logic [LEN_W-1:0] r_remain;
    logic             r_inflight;
    logic             r_inflight_last;
    logic             w_issue;
    logic             w_advance;
    logic [CW-1:0]    w_fifo_count;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CW:0]      w_occ;

    // Reads in flight count against FIFO space so a stalled consumer never overflows it.
    assign w_occ = (CW + 1)'(w_fifo_count) + (CW + 1)'(r_inflight);

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        wr_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_d_i     = '0;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                mem_we   = wr_valid;
                mem_d_i  = wr_data;
                if (wr_valid && (r_remain == '0)) begin
                    w_state_nxt = IDLE;
                end
            end
            READ: begin
                w_issue = (w_occ < (CW + 1)'(RSP_DEPTH));
                if (w_issue && (r_remain == '0)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_inflight && w_fifo_empty) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_advance = w_issue || ((r_state == WRITE) && wr_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_cur_addr      <= '0;
            r_remain        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remain == '0);
            if ((r_state == IDLE) && req_valid) begin
                r_cur_addr <= req_addr;
                r_remain   <= req_len;
            end else if (w_advance) begin
                r_cur_addr <= r_cur_addr + AW'(1);
                r_remain   <= r_remain - LEN_W'(1);
            end
        end
    end

    mem_rsp_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (RSP_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_inflight),
        .push_data ({r_inflight_last, mem_d_o}),
        .pop       (rsp_ready),
        .pop_data  ({rsp_last, rsp_data}),
        .count     (w_fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign rsp_valid = !w_fifo_empty;
    assign mem_addr  = r_cur_addr;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_initiator
// Description : Directed and randomized bench for mem_initiator with a
//               behavioural 256x8 write-first memory and reference array.
// Revision    : 1.0
// ============================================================================
module tb_mem_initiator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [7:0] req_addr = '0;
    logic [3:0] req_len = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_last;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_d_i;
    logic [7:0] mem_d_o;
    logic       busy;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_initiator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_d_i   (mem_d_i),
        .mem_d_o   (mem_d_o),
        .busy      (busy)
    );

    // Synchronous-read, write-first memory.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_d_i;
        mem_d_o <= mem_we ? mem_d_i : mem[mem_addr];
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: wr_valid always high, 1: 1,0,0,1 pattern then high, 2: random
    task automatic do_write(input logic [7:0] addr, input logic [3:0] len,
                            input logic [7:0] data[$], input int mode);
        int         beat = 0;
        int         att  = 0;
        logic [7:0] a    = addr;
        logic [3:0] pat  = 4'b1001;
        req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_len = len;
        #1 chk_val("wr_req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        while (beat <= int'(len)) begin
            case (mode)
                0:       wr_valid = 1'b1;
                1:       wr_valid = (att < 4) ? pat[3 - att] : 1'b1;
                default: wr_valid = ($urandom_range(0, 3) != 0) || (att > 20);
            endcase
            wr_data = data[beat];
            #1;
            chk_val("wr_ready", wr_ready, 1);
            chk_val("wr_mem_we", mem_we, wr_valid);
            chk_val("wr_mem_addr", mem_addr, a);
            if (wr_valid) chk_val("wr_mem_d_i", mem_d_i, data[beat]);
            @(negedge clk);
            if (wr_valid) begin
                ref_mem[a] = data[beat];
                chk_val("wr_in_mem", mem[a], data[beat]);
                a++;
                beat++;
            end
            att++;
        end
        wr_valid = 1'b0;
        #1;
        chk_val("wr_busy_fall", busy, 0);
        chk_val("wr_we_idle", mem_we, 0);
    endtask

    // mode 0: rsp_ready high, 1: low for 10 cycles then high, 2: random
    task automatic do_read(input logic [7:0] addr, input logic [3:0] len,
                           input int mode, input int abort_after);
        logic [8:0] exp_q[$];
        logic [8:0] prev = '0;
        logic       prev_stall = 1'b0;
        int cyc = 0, got = 0, first = -1, last_cyc = 0, peak = 0;
        for (int i = 0; i <= int'(len); i++)
            exp_q.push_back({(i == int'(len)), ref_mem[8'(int'(addr) + i)]});
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_len = len;
        #1 chk_val("rd_req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        while (exp_q.size() > 0 && cyc < 300) begin
            cyc++;
            case (mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = (cyc > 10);
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (int'(dut.w_fifo_count) > peak) peak = int'(dut.w_fifo_count);
            chk_val("rd_mem_we", mem_we, 0);
            if (prev_stall) begin
                chk_val("rsp_hold_valid", rsp_valid, 1);
                chk_val("rsp_hold_data", {rsp_last, rsp_data}, prev);
            end
            if (rsp_valid) begin
                if (first < 0) first = cyc;
                prev = {rsp_last, rsp_data};
            end
            prev_stall = rsp_valid && !rsp_ready;
            if (rsp_valid && rsp_ready) begin
                chk_val("rsp_beat", {rsp_last, rsp_data}, exp_q.pop_front());
                got++;
                last_cyc = cyc;
            end
            @(negedge clk);
            if (abort_after > 0 && got == abort_after) begin
                rst_n = 1'b0;
                rsp_ready = 1'b0;
                #1;
                chk_val("rst_rsp_valid", rsp_valid, 0);
                chk_val("rst_req_ready", req_ready, 1);
                chk_val("rst_busy", busy, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        rsp_ready = 1'b0;
        if (exp_q.size() > 0) chk_val("rd_timeout", 1, 0);
        if (mode == 0) begin
            chk_val("rd_first_latency", first, 3);
            chk_val("rd_no_bubbles", last_cyc - first, int'(len));
        end
        if (mode == 1) chk_val("rd_fifo_peak", peak, 3);
        for (int k = 0; k < 5 && busy; k++) @(negedge clk);
        #1;
        chk_val("rd_busy_fall", busy, 0);
        chk_val("rd_no_extra", rsp_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d[$];
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        chk_val("rst_req_ready", req_ready, 1);
        chk_val("rst_wr_ready", wr_ready, 0);
        chk_val("rst_rsp_valid", rsp_valid, 0);
        chk_val("rst_rsp_last", rsp_last, 0);
        chk_val("rst_mem_we", mem_we, 0);
        chk_val("rst_busy", busy, 0);
        chk_val("rst_mem_addr", mem_addr, 0);
        chk_val("rst_mem_d_i", mem_d_i, 0);
        chk_val("rst_rsp_data", rsp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_write(8'h10, 4'd3, d, 0);
        do_read(8'h10, 4'd3, 0, 0);

        d.delete();
        for (int i = 0; i < 8; i++) d.push_back(8'($urandom));
        do_write(8'h40, 4'd7, d, 2);
        do_read(8'h40, 4'd7, 1, 0);

        d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        do_write(8'hFE, 4'd3, d, 0);
        chk_val("wrap_mem_00", mem[8'h00], 8'hA2);
        chk_val("wrap_mem_01", mem[8'h01], 8'hA3);
        do_read(8'hFE, 4'd3, 0, 0);

        d = '{8'h5A, 8'hC3};
        do_write(8'h80, 4'd1, d, 1);
        do_read(8'h80, 4'd1, 0, 0);

        do_read(8'h40, 4'd7, 0, 2);
        @(negedge clk);
        do_read(8'h40, 4'd7, 0, 0);

        for (int n = 0; n < 30; n++) begin
            logic [7:0] a;
            logic [3:0] l;
            a = 8'($urandom);
            l = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                d.delete();
                for (int i = 0; i <= int'(l); i++) d.push_back(8'($urandom));
                do_write(a, l, d, 2);
            end else begin
                do_read(a, l, ($urandom_range(0, 1) == 1) ? 2 : 0, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
